// File: rtl/or1200_cnt_arb_pkg.sv
// Shared definitions for the counting round-robin arbiter.
// Contents: FSM state encoding, default channel count and counter width,
// and the wrap-around pointer advance used after each grant.
package or1200_cnt_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 4;

    // Pointer moves to the channel after the winner, wrapping at nreq.
    function automatic logic [2:0] next_ptr(input logic [2:0] idx, input int nreq);
        return (int'(idx) == nreq - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/or1200_cnt_arb_if.sv
// Bus bundle between requesters/config master and the counting arbiter.
// Requests, config strobes and irq clears flow master -> slave; grants,
// packed counts, sticky irqs and busy flow slave -> master.
interface or1200_cnt_arb_if #(
    parameter int NREQ = 4,
    parameter int CW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    gnt;
    logic               cfg_we;
    logic [2:0]         cfg_sel;
    logic [CW-1:0]      cfg_thr;
    logic [NREQ-1:0]    irq_clr;
    logic [NREQ*CW-1:0] cnt;
    logic [NREQ-1:0]    irq;
    logic               busy;

    modport master (
        output req, cfg_we, cfg_sel, cfg_thr, irq_clr,
        input  gnt, cnt, irq, busy
    );

    modport slave (
        input  req, cfg_we, cfg_sel, cfg_thr, irq_clr,
        output gnt, cnt, irq, busy
    );
endinterface

// File: rtl/or1200_rr_pick.sv
// Round-robin picker: first set bit of pending at or after ptr, with wrap.
// Latency: purely combinational. Backpressure: none; vld low when pending is 0.
// Ports: pending/ptr in; onehot, vld and the winner index out.
module or1200_rr_pick
    import or1200_cnt_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] pending,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] onehot,
    output logic            vld,
    output logic [2:0]      idx
);

    int j;

    always_comb begin
        onehot = '0;
        vld    = 1'b0;
        idx    = '0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr is always < NREQ, so one subtraction is enough to wrap.
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!vld && pending[j]) begin
                onehot[j] = 1'b1;
                vld       = 1'b1;
                idx       = 3'(j);
            end
        end
    end

endmodule

// File: rtl/or1200_cnt_arb.sv
// Round-robin arbiter that counts grants per channel, with optional sticky
// threshold interrupts. Latency: req -> registered one-cycle gnt next cycle.
// Backpressure: requesters hold req until granted; one grant per cycle.
// Ports: clk, rst (sync, active-low), bus (slave modport of or1200_cnt_arb_if).
// Build option: define OR1200_CNT_ARB_IRQ_EN for thresholds and irq flags;
// without it counters wrap freely and irq is tied low.
module or1200_cnt_arb
    import or1200_cnt_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
) (
    input  logic             clk,
    input  logic             rst,
    or1200_cnt_arb_if.slave  bus
);

    state_t             state;
    state_t             state_nxt;
    logic [NREQ-1:0]    gnt_q;
    logic [NREQ-1:0]    gnt_nxt;
    logic [NREQ-1:0]    pending;
    logic [NREQ-1:0]    pick_oh;
    logic               pick_vld;
    logic [2:0]         pick_idx;
    logic [2:0]         ptr_q;

    logic [CW-1:0]      cnt_q   [NREQ];
    logic [CW-1:0]      cnt_inc [NREQ];
    logic [NREQ-1:0]    hit;
    logic [NREQ-1:0]    cfg_hit;
    logic [NREQ*CW-1:0] cnt_flat;

`ifdef OR1200_CNT_ARB_IRQ_EN
    logic [CW-1:0]      thr_q   [NREQ];
    logic [NREQ-1:0]    irq_q;
`endif

    // A requester whose grant is currently showing must not be counted again.
    assign pending = bus.req & ~gnt_q;

    or1200_rr_pick #(.NREQ(NREQ)) u_pick (
        .pending (pending),
        .ptr     (ptr_q),
        .onehot  (pick_oh),
        .vld     (pick_vld),
        .idx     (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        gnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    gnt_nxt   = pick_oh;
                end
            end
            GRANT: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    gnt_nxt   = pick_oh;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Threshold compare uses the stored thr, so a same-edge cfg write only
    // affects the following increments.
    always_comb begin
        hit     = '0;
        cfg_hit = '0;
        for (int i = 0; i < NREQ; i++) begin
            cnt_inc[i] = cnt_q[i] + CW'(1);
            cfg_hit[i] = bus.cfg_we && (bus.cfg_sel == 3'(i));
`ifdef OR1200_CNT_ARB_IRQ_EN
            hit[i]     = gnt_q[i] && (thr_q[i] != '0) && (cnt_inc[i] == thr_q[i]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            gnt_q <= '0;
            ptr_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
`ifdef OR1200_CNT_ARB_IRQ_EN
                thr_q[i] <= '0;
`endif
            end
`ifdef OR1200_CNT_ARB_IRQ_EN
            irq_q <= '0;
`endif
        end else begin
            state <= state_nxt;
            gnt_q <= gnt_nxt;
            if (pick_vld) begin
                ptr_q <= next_ptr(pick_idx, NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                // Config clear beats both threshold reload and increment.
                if (cfg_hit[i] || hit[i]) begin
                    cnt_q[i] <= '0;
                end else if (gnt_q[i]) begin
                    cnt_q[i] <= cnt_inc[i];
                end
`ifdef OR1200_CNT_ARB_IRQ_EN
                if (cfg_hit[i]) begin
                    thr_q[i] <= bus.cfg_thr;
                end
                // Set dominates a simultaneous clear.
                irq_q[i] <= hit[i] | (irq_q[i] & ~bus.irq_clr[i]);
`endif
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < NREQ; i++) begin
            cnt_flat[i*CW +: CW] = cnt_q[i];
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.cnt  = cnt_flat;
    assign bus.busy = (state == GRANT);
`ifdef OR1200_CNT_ARB_IRQ_EN
    assign bus.irq  = irq_q;
`else
    assign bus.irq  = '0;
`endif

endmodule

// File: tb/tb_or1200_cnt_arb.sv
// Bench for or1200_cnt_arb: directed scenarios then random traffic, checked
// against a transaction-level reference model through two scoreboards
// (grant events, and per-edge counter/irq/busy snapshots).
module tb_or1200_cnt_arb;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    or1200_cnt_arb_if #(.NREQ(N), .CW(W)) bus ();

    or1200_cnt_arb #(.NREQ(N), .CW(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int edge_no; int idx; } gexp_t;
    typedef struct { logic [N*W-1:0] cnt; logic [N-1:0] irq; logic busy; } sexp_t;

    gexp_t gq[$];
    sexp_t sq[$];
    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    bit [N-1:0] m_gnt = '0;
    int         m_ptr = 0;
    int         m_cnt [N];
    int         m_thr [N];
    bit [N-1:0] m_irq = '0;
    int         drv_edge = 0;

    // Driver state
    logic [N-1:0] want     = '0;
    bit           hold     = 1'b0;
    bit           rnd      = 1'b0;
    logic         cfg_we_v = 1'b0;
    logic [2:0]   sel_v    = '0;
    logic [W-1:0] thr_v    = '0;
    logic [N-1:0] clr_v    = '0;
    logic         rst_v    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict the effect of the coming clock edge from the inputs just driven.
    task automatic model_step();
        bit [N-1:0] pend;
        bit [N-1:0] ng;
        int gi;
        int c;
        bit hitv;
        sexp_t s;
        drv_edge++;
        if (!rst_v) begin
            m_gnt = '0;
            m_ptr = 0;
            m_irq = '0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                m_thr[i] = 0;
            end
        end else begin
            pend = want & ~m_gnt;
            ng   = '0;
            gi   = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (gi < 0 && pend[j]) gi = j;
            end
            if (gi >= 0) begin
                ng[gi] = 1'b1;
                m_ptr  = (gi + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                hitv = 1'b0;
                if (m_gnt[i]) begin
                    c = (m_cnt[i] + 1) % (1 << W);
`ifdef OR1200_CNT_ARB_IRQ_EN
                    if (m_thr[i] != 0 && c == m_thr[i]) begin
                        hitv = 1'b1;
                        c    = 0;
                    end
`endif
                    m_cnt[i] = c;
                end
                m_irq[i] = hitv | (m_irq[i] & ~clr_v[i]);
                if (cfg_we_v && sel_v == i) begin
                    m_cnt[i] = 0;
                    m_thr[i] = int'(thr_v);
                end
            end
            m_gnt = ng;
            if (gi >= 0) gq.push_back('{edge_no: drv_edge, idx: gi});
        end
        for (int i = 0; i < N; i++) s.cnt[i*W +: W] = W'(m_cnt[i]);
`ifdef OR1200_CNT_ARB_IRQ_EN
        s.irq = m_irq;
`else
        s.irq = '0;
`endif
        s.busy = (m_gnt != '0);
        sq.push_back(s);
    endtask

    task automatic drive();
        bus.req     = want;
        bus.cfg_we  = cfg_we_v;
        bus.cfg_sel = sel_v;
        bus.cfg_thr = thr_v;
        bus.irq_clr = clr_v;
        rst         = rst_v;
        model_step();
    endtask

    task automatic tick();
        @(negedge clk);
        // Requesters drop req once they see their grant.
        if (!hold) want &= ~bus.gnt;
        if (rnd) begin
            want     |= N'($urandom & $urandom) & ~bus.gnt;
            cfg_we_v = ($urandom_range(0, 9) == 0);
            sel_v    = 3'($urandom_range(0, 7));
            thr_v    = W'($urandom_range(0, 6));
            clr_v    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rst_v    = ($urandom_range(0, 79) != 0);
        end
        drive();
        if (!rnd) begin
            cfg_we_v = 1'b0;
            clr_v    = '0;
        end
    endtask

    task automatic do_reset();
        rst_v = 1'b0;
        tick();
        rst_v = 1'b1;
    endtask

    task automatic grant(input int ch, input int n);
        repeat (n) begin
            want[ch] = 1'b1;
            repeat (3) tick();
        end
    endtask

    task automatic cfg(input int ch, input int thr);
        cfg_we_v = 1'b1;
        sel_v    = 3'(ch);
        thr_v    = W'(thr);
        tick();
    endtask

    // Monitor: compare DUT outputs just after every rising edge.
    initial begin
        int me;
        logic [N-1:0] g;
        sexp_t s;
        gexp_t e;
        me = 0;
        forever begin
            @(posedge clk);
            #1;
            me++;
            if (sq.size() == 0) begin
                check("snapshot_avail", 32'd0, 32'd1);
            end else begin
                s = sq.pop_front();
                check("cnt", 32'(bus.cnt), 32'(s.cnt));
                check("irq", 32'(bus.irq), 32'(s.irq));
                check("busy", 32'(bus.busy), 32'(s.busy));
            end
            g = bus.gnt;
            if (g != '0) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", 32'(g), 32'd0);
                end else begin
                    e = gq.pop_front();
                    check("gnt_edge", 32'(me), 32'(e.edge_no));
                    check("gnt_vec", 32'(g), 32'(1) << e.idx);
                end
            end
        end
    end

    initial begin
        rst_v = 1'b0;
        drive();
        tick();
        rst_v = 1'b1;

        // Single request: one grant, count 1, busy one cycle.
        want = 4'b0001;
        repeat (4) tick();

        // All four requesting from ptr 0: grants 0,1,2,3 back to back.
        do_reset();
        want = 4'b1111;
        repeat (7) tick();

        // Threshold 3 on channel 1, then clear its irq.
        cfg(1, 3);
        grant(1, 3);
        clr_v = 4'b0010;
        tick();
        tick();

        // Threshold 0 on channel 0: free wrap over sixteen grants.
        cfg(0, 0);
        grant(0, 16);

        // Config clear on the same edge as channel 2's increment.
        cfg(2, 0);
        grant(2, 1);
        want[2] = 1'b1;
        tick();
        cfg(2, 2);
        tick();
        // irq set and clear on the same edge.
        grant(2, 1);
        want[2] = 1'b1;
        tick();
        clr_v = 4'b0100;
        tick();
        tick();

        // Out-of-range select is ignored.
        cfg(5, 1);
        tick();

        // Reset while channel 3 is granted; held request is re-granted.
        do_reset();
        want = 4'b1000;
        tick();
        hold  = 1'b1;
        rst_v = 1'b0;
        tick();
        rst_v = 1'b1;
        hold  = 1'b0;
        repeat (4) tick();

        // Random traffic.
        rnd = 1'b1;
        repeat (800) tick();
        rnd      = 1'b0;
        rst_v    = 1'b1;
        cfg_we_v = 1'b0;
        clr_v    = '0;
        want     = '0;
        repeat (4) tick();

        @(posedge clk);
        #2;
        check("gnt_queue_drained", 32'(gq.size()), 32'd0);
        check("snap_queue_drained", 32'(sq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
